if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction field decoder. It holds the PC and fetches words from instruction memory over a req/ack handshake. It presents each fetched word (`ins`) plus its PC in a one-entry output buffer with valid/ready flow control. It computes redirect targets for branch, j and jr from fields handed back by decode/execute.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address of the current fetch.
- imem_req  out  1  fetch request; held until acked.
- imem_ack  in  1  imem_data valid this cycle; completes the request.
- imem_data  in  32  instruction word.
- ins  out  32  buffered instruction; drives the field decoder.
- ins_pc  out  32  PC of `ins`.
- ins_valid  out  1  `ins`/`ins_pc` hold a live instruction.
- id_ready  in  1  downstream consumes when ins_valid & id_ready.
- redirect  in  1  control-flow change; flush and refetch.
- npc_sel  in  2  00 fall-through, 01 branch, 10 j/jal, 11 jr.
- base_pc  in  32  PC of the redirecting instruction.
- br_imm16  in  16  branch offset (decoder imm16).
- j_target  in  26  jump index (decoder target).
- jr_addr  in  32  register value for jr.

Behaviour:
- Reset (async, immediate) values:
  - pc=RESET_PC, drain_pc=0, state=FETCH.
  - ins=0, ins_pc=0, ins_valid=0.
  - imem_req=0 while reset is high.
- States: FETCH, DRAIN.
- `slot_free` = !ins_valid | id_ready.
- FETCH:
  - imem_addr=pc; imem_req=slot_free.
  - Once imem_req rises it stays high with imem_addr stable until ack. The memory requires a stable address.
  - If imem_req is low and slot_free becomes true, the request is issued.
- Ack in FETCH without redirect:
  - ins<=imem_data, ins_pc<=pc, ins_valid<=1, pc<=pc+4.
  - Throughput: 1 instr/cycle when ack is same-cycle and id_ready is held high.
- Consume without a new ack: ins_valid<=0.
- While ins_valid & !id_ready: ins and ins_pc are held bit-stable.
- Redirect (highest priority, any state):
  - ins_valid<=0 (buffer flushed, even if id_ready=1 that cycle).
  - pc<=npc.
- npc, mod 2^32, where p4 = base_pc+4:
  - 00: p4.
  - 01: p4 + (sign-extend(br_imm16)<<2).
  - 10: {p4[31:28], j_target, 2'b00}.
  - 11: jr_addr (no alignment check; passed as-is).
- Redirect in FETCH with imem_req=1 & imem_ack=0:
  - drain_pc<=pc (current outstanding address); state<=DRAIN.
- Redirect in FETCH with imem_ack=1: returned data is discarded; stay FETCH, next request at npc.
- Redirect in FETCH with imem_req=0: stay FETCH.
- DRAIN:
  - imem_req=1, imem_addr=drain_pc.
  - On ack: data discarded, ins_valid unaffected, state<=FETCH.
  - Redirect during DRAIN: pc<=npc, stay DRAIN, drain_pc unchanged.
  - Redirect coincident with the drain ack: pc<=npc, state<=FETCH.
- No fetched word is ever delivered from a pre-redirect address after the redirect cycle.
- PC wrap: 32'hFFFF_FFFC+4 = 0, no flag.
- Reset mid-request: request dropped; after release, first request is at RESET_PC.

Test Plan:
1. Sequential run: reset, release, memory acks every cycle, id_ready=1 → ins_pc 0x3000, 0x3004, 0x3008 on consecutive cycles, ins equals mem[addr], ins_valid stays 1.
2. Backpressure: id_ready=0 for 3 cycles after first word (0x3000) → ins and ins_pc frozen, imem_req=0. id_ready=1 → next request addr 0x3004, no word lost or duplicated.
3. Branch redirect: base_pc=0x3008, npc_sel=01, br_imm16=0xFFFE → next delivered ins_pc=0x3004; the buffered word at redirect is never consumed.
4. Jump and jr:
   - base_pc=0x3010, npc_sel=10, j_target=0x0000C40 → fetch addr 0x00003100.
   - npc_sel=11, jr_addr=0x0000_3ABC → fetch addr 0x3ABC.
5. Redirect during 3-cycle memory latency: outstanding fetch 0x300C, redirect to 0x3200 → imem_addr stays 0x300C until ack, that data is dropped, next request 0x3200 and its word delivered first.
6. Async reset asserted mid-DRAIN, without a clock edge → outputs immediately zero, ins_valid=0, imem_req=0. After release, first imem_addr=0x3000.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack memory
// handshake, buffers one instruction with valid/ready flow control and
// computes redirect targets for branch, j/jal and jr.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] base_pc,
  input  logic [15:0] br_imm16,
  input  logic [25:0] j_target,
  input  logic [31:0] jr_addr
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] drain_pc_r;
  logic        hold_r;       // a request is outstanding and must stay raised
  logic        slot_free_s;
  logic        fire_s;
  logic [31:0] npc_s;

  // Next-PC selection; all arithmetic wraps mod 2^32.
  function automatic logic [31:0] calc_npc(
    input logic [1:0]  sel,
    input logic [31:0] base,
    input logic [15:0] imm,
    input logic [25:0] tgt,
    input logic [31:0] jr
  );
    logic [31:0] p4;
    p4 = base + 32'd4;
    case (sel)
      2'b00:   calc_npc = p4;
      2'b01:   calc_npc = p4 + {{14{imm[15]}}, imm, 2'b00};
      2'b10:   calc_npc = {p4[31:28], tgt, 2'b00};
      2'b11:   calc_npc = jr;
      default: calc_npc = p4;
    endcase
  endfunction

  // Buffer availability, handshake completion and redirect target.
  always_comb begin
    slot_free_s = !ins_valid || id_ready;
    fire_s      = imem_req && imem_ack;
    npc_s       = calc_npc(npc_sel, base_pc, br_imm16, j_target, jr_addr);
  end

  // Memory request: drained address in DRAIN, otherwise the PC while the
  // buffer can accept a word or a request is already outstanding.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_r;
    if (reset) begin
      imem_req  = 1'b0;
      imem_addr = pc_r;
    end else begin
      case (state_r)
        FETCH: begin
          imem_req  = hold_r || slot_free_s;
          imem_addr = pc_r;
        end
        DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = drain_pc_r;
        end
        default: begin
          imem_req  = 1'b0;
          imem_addr = pc_r;
        end
      endcase
    end
  end

  // Fetch FSM, PC and one-entry output buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      drain_pc_r <= 32'h0000_0000;
      hold_r     <= 1'b0;
      ins        <= 32'h0000_0000;
      ins_pc     <= 32'h0000_0000;
      ins_valid  <= 1'b0;
    end else if (redirect) begin
      // Flush and steer; an unanswered request must still be drained
      // from memory at its original address.
      pc_r      <= npc_s;
      ins_valid <= 1'b0;
      hold_r    <= 1'b0;
      case (state_r)
        FETCH: begin
          if (imem_req && !imem_ack) begin
            drain_pc_r <= pc_r;
            state_r    <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state_r <= FETCH;
          end
        end
        default: state_r <= FETCH;
      endcase
    end else begin
      case (state_r)
        FETCH: begin
          if (fire_s) begin
            hold_r <= 1'b0;
            // A word that arrives while the buffer is stalled is dropped
            // and the same PC is fetched again later.
            if (slot_free_s) begin
              ins       <= imem_data;
              ins_pc    <= pc_r;
              ins_valid <= 1'b1;
              pc_r      <= pc_r + 32'd4;
            end
          end else begin
            hold_r <= imem_req;
            if (ins_valid && id_ready) begin
              ins_valid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state_r <= FETCH;
          end
          if (ins_valid && id_ready) begin
            ins_valid <= 1'b0;
          end
        end
        default: state_r <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder with variable latency, directed
// scenarios and a randomized phase; delivered instructions are checked by a
// monitor against an expected PC stream kept by the bench.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic [31:0] base_pc = 32'h0;
  logic [15:0] br_imm16 = 16'h0;
  logic [25:0] j_target = 26'h0;
  logic [31:0] jr_addr = 32'h0;

  int n_vec = 0;
  int n_mis = 0;
  int lat_mode = 0;      // 0 or 2: fixed extra wait cycles, 3: random 0..3
  int consumed = 0;
  logic [31:0] redir_q[$];

  if_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid),
    .id_ready(id_ready), .redirect(redirect), .npc_sel(npc_sel),
    .base_pc(base_pc), .br_imm16(br_imm16), .j_target(j_target),
    .jr_addr(jr_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F96;
  endfunction

  // Architectural next-PC rules.
  function automatic logic [31:0] model_npc(input logic [1:0] sel, input logic [31:0] base,
                                            input logic [15:0] imm, input logic [25:0] tgt,
                                            input logic [31:0] jr);
    logic [31:0] p4;
    int off;
    p4  = base + 32'd4;
    off = int'($signed(imm)) * 4;
    case (sel)
      2'd0:    return p4;
      2'd1:    return p4 + 32'(off);
      2'd2:    return (p4 & 32'hF000_0000) + (32'(tgt) * 32'd4);
      default: return jr;
    endcase
  endfunction

  task automatic drive_redirect(input logic [1:0] sel, input logic [31:0] base,
                                input logic [15:0] imm, input logic [25:0] tgt,
                                input logic [31:0] jr);
    redirect = 1'b1;
    npc_sel  = sel;
    base_pc  = base;
    br_imm16 = imm;
    j_target = tgt;
    jr_addr  = jr;
    redir_q.push_back(model_npc(sel, base, imm, tgt, jr));
  endtask

  // Memory responder, also checking that an unanswered request is held stable.
  int wait_cnt = 0;
  int cur_lat = 0;
  logic prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      imem_ack  = 1'b0;
      wait_cnt  = 0;
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        check("req_held", {31'b0, imem_req}, 32'd1);
        check("addr_stable", imem_addr, prev_addr);
      end
      if (imem_req) begin
        if (wait_cnt == 0) cur_lat = (lat_mode == 3) ? int'($urandom_range(0, 3)) : lat_mode;
        if (wait_cnt >= cur_lat) begin
          imem_ack  = 1'b1;
          imem_data = memword(imem_addr);
          wait_cnt  = 0;
        end else begin
          imem_ack  = 1'b0;
          imem_data = $urandom;
          wait_cnt++;
        end
      end else begin
        imem_ack  = 1'b0;
        imem_data = $urandom;
        wait_cnt  = 0;
      end
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
  end

  // Monitor: every consumed instruction must be the next one in program order.
  logic [31:0] exp_pc = 32'h0000_3000;
  logic        stalled = 1'b0;
  logic [31:0] held_ins, held_pc;
  always @(negedge clk) begin
    if (reset) begin
      exp_pc  = 32'h0000_3000;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {31'b0, ins_valid}, 32'd1);
        check("stall_ins", ins, held_ins);
        check("stall_pc", ins_pc, held_pc);
      end
      if (redirect) begin
        stalled = 1'b0;
        if (redir_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL redir_q: got empty expected target");
        end else begin
          exp_pc = redir_q.pop_front();
        end
      end else begin
        if (ins_valid && id_ready) begin
          check("deliver_pc", ins_pc, exp_pc);
          check("deliver_ins", ins, memword(exp_pc));
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        stalled  = ins_valid && !id_ready;
        held_ins = ins;
        held_pc  = ins_pc;
      end
    end
  end

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #1;
    redir_q.delete();
    redirect = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("rst_ins", ins, 32'h0);
    check("rst_ins_pc", ins_pc, 32'h0);
    check("rst_valid", {31'b0, ins_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    id_ready = rdy;
    reset    = 1'b0;
    @(negedge clk);
    check("first_addr", imem_addr, 32'h0000_3000);
    check("first_req", {31'b0, imem_req}, 32'd1);
  endtask

  initial begin
    logic [31:0] base;
    // Sequential run at full throughput.
    lat_mode = 0;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("seq_pc", ins_pc, 32'h0000_3000 + 32'(i) * 32'd4);
      check("seq_valid", {31'b0, ins_valid}, 32'd1);
    end

    // Backpressure after the first word.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req", {31'b0, imem_req}, 32'd0);
      check("bp_pc", ins_pc, 32'h0000_3000);
      check("bp_ins", ins, memword(32'h0000_3000));
    end
    @(posedge clk); #1;
    id_ready = 1'b1;
    @(negedge clk);
    check("bp_next_addr", imem_addr, 32'h0000_3004);
    repeat (3) @(posedge clk);

    // Branch, j and jr redirects.
    #1; drive_redirect(2'b01, 32'h0000_3008, 16'hFFFE, 26'h0, 32'h0);
    @(posedge clk); #1; redirect = 1'b0;
    @(negedge clk); check("br_addr", imem_addr, 32'h0000_3004);
    @(posedge clk); #1; drive_redirect(2'b10, 32'h0000_3010, 16'h0, 26'h0000C40, 32'h0);
    @(posedge clk); #1; redirect = 1'b0;
    @(negedge clk); check("j_addr", imem_addr, 32'h0000_3100);
    @(posedge clk); #1; drive_redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_3ABC);
    @(posedge clk); #1; redirect = 1'b0;
    @(negedge clk); check("jr_addr", imem_addr, 32'h0000_3ABC);

    // Redirect while a 3-cycle fetch is outstanding.
    @(posedge clk); #1; id_ready = 1'b0; lat_mode = 2;
    repeat (8) @(posedge clk);
    #1; drive_redirect(2'b00, 32'h0000_3008, 16'h0, 26'h0, 32'h0);
    @(posedge clk); #1; drive_redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_3200);
    @(negedge clk); check("drain_addr0", imem_addr, 32'h0000_300C);
    @(posedge clk); #1; redirect = 1'b0;
    @(negedge clk); check("drain_addr1", imem_addr, 32'h0000_300C);
    @(negedge clk); check("drain_addr2", imem_addr, 32'h0000_300C);
    @(posedge clk); #1; id_ready = 1'b1;
    @(negedge clk); check("post_drain_addr", imem_addr, 32'h0000_3200);
    repeat (10) @(posedge clk);

    // Asynchronous reset while draining.
    #1; id_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1; drive_redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_3400);
    @(posedge clk); #1; drive_redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_3500);
    @(posedge clk); #1; redirect = 1'b0;
    #2; redir_q.delete(); reset = 1'b1;
    #1;
    check("async_ins", ins, 32'h0);
    check("async_ins_pc", ins_pc, 32'h0);
    check("async_valid", {31'b0, ins_valid}, 32'd0);
    check("async_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1; reset = 1'b0; id_ready = 1'b1;
    @(negedge clk); check("async_first_addr", imem_addr, 32'h0000_3000);

    // Randomized phase.
    lat_mode = 3;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      id_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 15) == 0) base = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
        else base = 32'h0000_3000 + 32'($urandom_range(0, 255)) * 32'd4;
        drive_redirect(2'($urandom_range(0, 3)), base, 16'($urandom), 26'($urandom), $urandom);
      end else begin
        redirect = 1'b0;
        npc_sel  = 2'($urandom_range(0, 3));
        base_pc  = $urandom;
        jr_addr  = $urandom;
      end
    end
    @(posedge clk); #1; redirect = 1'b0; id_ready = 1'b1;
    repeat (10) @(posedge clk);
    check("liveness", {31'b0, (consumed >= 200)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
